// File: rtl/wb_master_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter with fixed-priority or round-robin
// selection, whole-CYC ownership and a stalled-strobe watchdog.
module wb_master_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_MASTERS*ADDRESS_WIDTH-1:0]  m_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
    input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS-1:0]                m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                m_stb_i,
    input  logic [3*NUM_MASTERS-1:0]              m_cti_i,
    input  logic [2*NUM_MASTERS-1:0]              m_bte_i,
    output logic [DATA_WIDTH-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]                m_ack_o,
    output logic [NUM_MASTERS-1:0]                m_err_o,
    output logic [NUM_MASTERS-1:0]                m_rty_o,
    output logic [ADDRESS_WIDTH-1:0]              s_adr_o,
    output logic [DATA_WIDTH-1:0]                 s_dat_o,
    output logic [DATA_WIDTH/8-1:0]               s_sel_o,
    output logic                                  s_we_o,
    output logic                                  s_cyc_o,
    output logic                                  s_stb_o,
    output logic [2:0]                            s_cti_o,
    output logic [1:0]                            s_bte_o,
    input  logic [DATA_WIDTH-1:0]                 s_dat_i,
    input  logic                                  s_ack_i,
    input  logic                                  s_err_i,
    input  logic                                  s_rty_i,
    output logic [NUM_MASTERS-1:0]                grant_o,
    output logic                                  timeout_o,
    output logic [1:0]                            dbg_state_o
);

    // Handshake: a beat is offered while CYC and STB are high and completes in the
    // cycle the slave raises ACK, ERR or RTY; CYC high alone keeps ownership.
    localparam int SW = DATA_WIDTH / 8;
    localparam int OW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_MASTERS - 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam bit            WDOG_EN   = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   w_owner_nxt;
    logic [OW-1:0]   r_rr_ptr;
    logic [OW-1:0]   w_rr_nxt;
    logic [OW-1:0]   w_owner_inc;
    logic [OW-1:0]   w_winner;
    logic            w_found;
    int              w_scan_idx;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_any_cyc;
    logic            w_stall;
    logic            w_limit;

    logic [ADDRESS_WIDTH-1:0] w_own_adr;
    logic [DATA_WIDTH-1:0]    w_own_dat;
    logic [SW-1:0]            w_own_sel;
    logic                     w_own_we;
    logic                     w_own_cyc;
    logic                     w_own_stb;
    logic [2:0]               w_own_cti;
    logic [1:0]               w_own_bte;

    // Request mux selected by the registered owner.
    always_comb begin
        w_own_adr = '0;
        w_own_dat = '0;
        w_own_sel = '0;
        w_own_we  = 1'b0;
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_cti = '0;
        w_own_bte = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_owner == OW'(k)) begin
                w_own_adr = m_adr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                w_own_dat = m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                w_own_sel = m_sel_i[k*SW +: SW];
                w_own_we  = m_we_i[k];
                w_own_cyc = m_cyc_i[k];
                w_own_stb = m_stb_i[k];
                w_own_cti = m_cti_i[k*3 +: 3];
                w_own_bte = m_bte_i[k*2 +: 2];
            end
        end
    end

    // Winner scan starts at the rr pointer in round-robin mode, at 0 otherwise.
    always_comb begin
        w_winner   = '0;
        w_found    = 1'b0;
        w_scan_idx = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_scan_idx = i + ((ARB_MODE == 1) ? int'(r_rr_ptr) : 0);
            if (w_scan_idx >= NUM_MASTERS) begin
                w_scan_idx = w_scan_idx - NUM_MASTERS;
            end
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!w_found && (j == w_scan_idx) && m_cyc_i[j]) begin
                    w_found  = 1'b1;
                    w_winner = OW'(j);
                end
            end
        end
    end

    assign w_any_cyc   = |m_cyc_i;
    assign w_owner_inc = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
    assign w_stall     = w_own_stb & ~(s_ack_i | s_err_i | s_rty_i);
    assign w_limit     = (r_cnt == CNT_LIMIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any_cyc) begin
                    w_state_nxt = S_OWN;
                    w_owner_nxt = w_winner;
                end
            end
            S_OWN: begin
                // A dropped CYC or a termination always beats the watchdog.
                if (!w_own_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = w_owner_inc;
                end else if (WDOG_EN && w_stall) begin
                    if (w_limit) begin
                        w_state_nxt = S_ABORT;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            S_ABORT: begin
                if (w_own_cyc) begin
                    w_state_nxt = S_OWN;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_rr_nxt    = w_owner_inc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_cti_o   = '0;
        s_bte_o   = '0;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_rty_o   = '0;
        grant_o   = '0;
        timeout_o = 1'b0;
        case (r_state)
            S_OWN: begin
                s_adr_o = w_own_adr;
                s_dat_o = w_own_dat;
                s_sel_o = w_own_sel;
                s_we_o  = w_own_we;
                s_cyc_o = w_own_cyc;
                s_stb_o = w_own_stb;
                s_cti_o = w_own_cti;
                s_bte_o = w_own_bte;
                for (int k = 0; k < NUM_MASTERS; k++) begin
                    if (r_owner == OW'(k)) begin
                        m_ack_o[k] = s_ack_i;
                        m_err_o[k] = s_err_i;
                        m_rty_o[k] = s_rty_i;
                        grant_o[k] = 1'b1;
                    end
                end
            end
            S_ABORT: begin
                timeout_o = 1'b1;
                for (int k = 0; k < NUM_MASTERS; k++) begin
                    if (r_owner == OW'(k)) begin
                        m_err_o[k] = 1'b1;
                        grant_o[k] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign m_dat_o     = s_dat_i;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench: instance 0 is fixed priority, instance 1 round-robin, both
// two masters with an 8-cycle watchdog; each instance has its own stimulus set.
module tb_wb_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N*AW-1:0] m_adr [2];
  logic [N*DW-1:0] m_dat [2];
  logic [N*SW-1:0] m_sel [2];
  logic [N-1:0]    m_we  [2];
  logic [N-1:0]    m_cyc [2];
  logic [N-1:0]    m_stb [2];
  logic [3*N-1:0]  m_cti [2];
  logic [2*N-1:0]  m_bte [2];
  logic [DW-1:0]   s_dat [2];
  logic            s_ack [2];
  logic            s_err [2];
  logic            s_rty [2];

  logic [DW-1:0]   m_dat_o   [2];
  logic [N-1:0]    m_ack_o   [2];
  logic [N-1:0]    m_err_o   [2];
  logic [N-1:0]    m_rty_o   [2];
  logic [AW-1:0]   s_adr_o   [2];
  logic [DW-1:0]   s_dat_o   [2];
  logic [SW-1:0]   s_sel_o   [2];
  logic            s_we_o    [2];
  logic            s_cyc_o   [2];
  logic            s_stb_o   [2];
  logic [2:0]      s_cti_o   [2];
  logic [1:0]      s_bte_o   [2];
  logic [N-1:0]    grant_o   [2];
  logic            timeout_o [2];
  logic [1:0]      dbg_state [2];

  int n_cmp = 0;
  int n_mis = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_master_arbiter #(
      .NUM_MASTERS(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
      .ARB_MODE(g), .TIMEOUT_CYCLES(8)
    ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .m_adr_i(m_adr[g]), .m_dat_i(m_dat[g]), .m_sel_i(m_sel[g]),
      .m_we_i(m_we[g]), .m_cyc_i(m_cyc[g]), .m_stb_i(m_stb[g]),
      .m_cti_i(m_cti[g]), .m_bte_i(m_bte[g]),
      .m_dat_o(m_dat_o[g]), .m_ack_o(m_ack_o[g]), .m_err_o(m_err_o[g]), .m_rty_o(m_rty_o[g]),
      .s_adr_o(s_adr_o[g]), .s_dat_o(s_dat_o[g]), .s_sel_o(s_sel_o[g]), .s_we_o(s_we_o[g]),
      .s_cyc_o(s_cyc_o[g]), .s_stb_o(s_stb_o[g]), .s_cti_o(s_cti_o[g]), .s_bte_o(s_bte_o[g]),
      .s_dat_i(s_dat[g]), .s_ack_i(s_ack[g]), .s_err_i(s_err[g]), .s_rty_i(s_rty[g]),
      .grant_o(grant_o[g]), .timeout_o(timeout_o[g]), .dbg_state_o(dbg_state[g])
    );
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs(input int d);
    m_adr[d] = '0; m_dat[d] = '0; m_sel[d] = '0; m_we[d] = '0;
    m_cyc[d] = '0; m_stb[d] = '0; m_cti[d] = '0; m_bte[d] = '0;
    s_dat[d] = '0; s_ack[d] = 1'b0; s_err[d] = 1'b0; s_rty[d] = 1'b0;
  endtask

  // Four rounds of both masters requesting at the same IDLE edge; the owner
  // completes one beat and drops CYC. exp_seq holds the expected grant per round.
  task automatic arb_rounds(input int d, input logic [7:0] exp_seq);
    logic [1:0] g;
    for (int r = 0; r < 4; r++) begin
      g = exp_seq[2*r +: 2];
      m_cyc[d] = 2'b11; m_stb[d] = 2'b11; s_ack[d] = 1'b1;
      settle();
      check_eq($sformatf("d%0d_r%0d_idle_grant", d, r), grant_o[d], 2'b00);
      step();
      check_eq($sformatf("d%0d_r%0d_grant", d, r), grant_o[d], g);
      check_eq($sformatf("d%0d_r%0d_ack", d, r), m_ack_o[d], g);
      m_cyc[d] = 2'b11 & ~g; m_stb[d] = 2'b11 & ~g; s_ack[d] = 1'b0;
      step();
      check_eq($sformatf("d%0d_r%0d_gap", d, r), {grant_o[d], s_cyc_o[d]}, 3'b000);
    end
  endtask

  initial begin
    clear_inputs(0);
    clear_inputs(1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    settle();

    // Reset state
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rst_state", d), dbg_state[d], 2'd0);
      check_eq($sformatf("d%0d_rst_outs", d),
               {grant_o[d], m_ack_o[d], m_err_o[d], m_rty_o[d], s_cyc_o[d], s_stb_o[d], timeout_o[d]},
               '0);
      check_eq($sformatf("d%0d_rst_sadr", d), s_adr_o[d], '0);
    end
    s_dat[0] = 32'h1234_5678;
    settle();
    check_eq("dat_follow", m_dat_o[0], 32'h1234_5678);
    s_dat[0] = '0;

    // Single read by master 0, slave acks on the third owned cycle
    m_adr[0] = {32'h5555_0000, 32'h1000_0040};
    m_sel[0] = 8'h3F;
    m_cyc[0] = 2'b01; m_stb[0] = 2'b01;
    settle();
    check_eq("rd_latency", grant_o[0], 2'b00);
    step();
    check_eq("rd_grant", grant_o[0], 2'b01);
    check_eq("rd_scyc", s_cyc_o[0], 1'b1);
    check_eq("rd_sadr", s_adr_o[0], 32'h1000_0040);
    check_eq("rd_ssel", s_sel_o[0], 4'hF);
    check_eq("rd_noack", m_ack_o[0], 2'b00);
    step();
    step();
    s_ack[0] = 1'b1; s_dat[0] = 32'hDEAD_BEEF;
    settle();
    check_eq("rd_ack", m_ack_o[0], 2'b01);
    check_eq("rd_data", m_dat_o[0], 32'hDEAD_BEEF);
    step();
    s_ack[0] = 1'b0; s_dat[0] = '0; m_cyc[0] = 2'b00; m_stb[0] = 2'b00;
    settle();
    check_eq("rd_hold_grant", grant_o[0], 2'b01);
    check_eq("rd_scyc_follow", s_cyc_o[0], 1'b0);
    step();
    check_eq("rd_release", grant_o[0], 2'b00);

    // Fixed priority: master 0 wins every simultaneous request
    arb_rounds(0, 8'b01_01_01_01);
    step();
    check_eq("fix_m1_after", grant_o[0], 2'b10);
    m_cyc[0] = 2'b00; m_stb[0] = 2'b00;
    step();
    check_eq("fix_m1_release", grant_o[0], 2'b00);

    // Round-robin alternation
    arb_rounds(1, 8'b10_01_10_01);
    m_cyc[1] = 2'b00; m_stb[1] = 2'b00;
    step();
    check_eq("rr_stay_idle", grant_o[1], 2'b00);

    // Master 1 four-beat incrementing write burst while master 0 waits
    m_cyc[1] = 2'b10; m_stb[1] = 2'b10; m_we[1] = 2'b10;
    step();
    check_eq("burst_grant", grant_o[1], 2'b10);
    m_cyc[1] = 2'b11; m_stb[1] = 2'b11;
    for (int b = 0; b < 4; b++) begin
      m_adr[1][63:32] = 32'h2000_0000 + 32'(4 * b);
      m_dat[1][63:32] = 32'hA000_0000 + 32'(b);
      m_cti[1][5:3]   = (b == 3) ? 3'b111 : 3'b010;
      s_ack[1] = 1'b1;
      settle();
      check_eq($sformatf("burst_b%0d_grant", b), grant_o[1], 2'b10);
      check_eq($sformatf("burst_b%0d_adr", b), s_adr_o[1], 32'h2000_0000 + 32'(4 * b));
      check_eq($sformatf("burst_b%0d_dat", b), s_dat_o[1], 32'hA000_0000 + 32'(b));
      check_eq($sformatf("burst_b%0d_cti", b), s_cti_o[1], (b == 3) ? 3'b111 : 3'b010);
      check_eq($sformatf("burst_b%0d_we", b), s_we_o[1], 1'b1);
      check_eq($sformatf("burst_b%0d_ack", b), m_ack_o[1], 2'b10);
      step();
    end
    m_cyc[1] = 2'b01; m_stb[1] = 2'b01; m_we[1] = 2'b00; m_cti[1] = '0; s_ack[1] = 1'b0;
    settle();
    check_eq("burst_tail_grant", grant_o[1], 2'b10);
    step();
    check_eq("burst_gap", {grant_o[1], s_cyc_o[1]}, 3'b000);
    step();
    check_eq("burst_m0_after", grant_o[1], 2'b01);
    m_cyc[1] = 2'b00; m_stb[1] = 2'b00;
    step();
    check_eq("burst_m0_release", grant_o[1], 2'b00);

    // Watchdog: slave never responds, abort one cycle after the counter hits 8
    m_adr[0] = {32'h0, 32'h3000_0000};
    m_cyc[0] = 2'b01; m_stb[0] = 2'b01;
    step();
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("wd_stall_%0d", i), {timeout_o[0], m_err_o[0], s_cyc_o[0]}, 4'b0001);
      step();
    end
    check_eq("wd_abort", {timeout_o[0], m_err_o[0], s_cyc_o[0], s_stb_o[0]}, 5'b1_01_00);
    check_eq("wd_abort_state", dbg_state[0], 2'd2);
    step();
    check_eq("wd_reown", {timeout_o[0], m_err_o[0], s_cyc_o[0]}, 4'b0001);
    repeat (8) step();
    s_ack[0] = 1'b1;
    settle();
    check_eq("wd_limit_ack", m_ack_o[0], 2'b01);
    check_eq("wd_limit_noerr", {timeout_o[0], m_err_o[0]}, 3'b000);
    step();
    check_eq("wd_ack_wins", {timeout_o[0], m_err_o[0], s_cyc_o[0]}, 4'b0001);
    s_ack[0] = 1'b0; m_cyc[0] = 2'b00; m_stb[0] = 2'b00;
    step();
    check_eq("wd_release", grant_o[0], 2'b00);

    // Asynchronous reset mid-burst on the round-robin instance (rr pointer is 1 here)
    m_cyc[1] = 2'b10; m_stb[1] = 2'b10; m_cti[1] = 6'b010_000; s_ack[1] = 1'b1;
    step();
    check_eq("rst_burst_grant", grant_o[1], 2'b10);
    step();
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_async", {grant_o[1], s_cyc_o[1], s_stb_o[1], m_ack_o[1], m_err_o[1], timeout_o[1]},
             '0);
    clear_inputs(1);
    step();
    rst = 1'b0;
    m_cyc[1] = 2'b11; m_stb[1] = 2'b11;
    step();
    check_eq("rst_rr_ptr0", grant_o[1], 2'b01);
    m_cyc[1] = 2'b00; m_stb[1] = 2'b00;
    step();
    check_eq("rst_final_release", grant_o[1], 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_master_arbiter.md
# wb_master_arbiter

Parametrised N-master to 1-slave Wishbone B3 arbiter with bus-timeout watchdog. It sits between the CPU wrapper's instruction/data masters (plus optional debug or DMA masters) and the SoC interconnect, so a single-port slave fabric can serve all CPU buses. It supports fixed-priority and round-robin arbitration, burst/lock retention via CYC, and aborts hung cycles with ERR to the owning master.

## Interface
- NUM_MASTERS, 2, number of master ports (1..8)
- ADDRESS_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; SEL width SW = DATA_WIDTH/8
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT_CYCLES, 255, stalled-cycle limit before abort; 0 disables the watchdog

- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- m_adr_i  in  NUM_MASTERS*ADDRESS_WIDTH  packed master addresses, master k at [k*AW +: AW]
- m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed master write data
- m_sel_i  in  NUM_MASTERS*SW  packed byte selects
- m_we_i, m_cyc_i, m_stb_i  in  NUM_MASTERS  per-master control
- m_cti_i  in  3*NUM_MASTERS; m_bte_i  in  2*NUM_MASTERS  burst type
- m_dat_o  out  DATA_WIDTH  slave read data broadcast to all masters
- m_ack_o, m_err_o, m_rty_o  out  NUM_MASTERS  per-master termination
- s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  (matching widths)  slave-side request
- s_dat_i  in  DATA_WIDTH; s_ack_i, s_err_i, s_rty_i  in  1  slave response
- grant_o  out  NUM_MASTERS  one-hot current owner (0 when idle)
- timeout_o  out  1  one-cycle pulse on watchdog abort

## Operation
- FSM states: IDLE, OWN, ABORT. Reset: IDLE, grant_o=0, rr pointer=0, counter=0.
- IDLE: if any m_cyc_i high, register owner = winner, go OWN. Fixed: lowest set index. Round-robin: first set index at or above rr pointer, wrapping.
- OWN: s_* = owner's inputs (mux on registered owner); s_cyc_o = owner m_cyc_i. m_ack/err/rty_o[owner] = s_ack/err/rty_i combinationally; non-owners 0. m_dat_o = s_dat_i always.
- OWN exit: owner m_cyc_i low at clock edge -> IDLE, grant_o=0, rr pointer = owner+1 mod NUM_MASTERS. Ownership is held for the whole CYC (bursts and locked RMW never split).
- Watchdog (TIMEOUT_CYCLES>0): counter, width $clog2(TIMEOUT_CYCLES+1), increments each OWN cycle with s_stb_o high and no s_ack/err/rty_i; clears on any termination, on s_stb_o low, or on leaving OWN. When counter == TIMEOUT_CYCLES and still unterminated -> ABORT.
- ABORT (1 cycle): s_cyc_o=s_stb_o=0, m_err_o[owner]=1, timeout_o=1, counter cleared. Next: OWN if owner m_cyc_i still high, else IDLE (rr update as OWN exit).
- Outside OWN: all s_* outputs 0, all m_ack/err/rty_o 0.

## Timing
- Reset values: every output 0 (m_dat_o follows s_dat_i).
- Arbitration latency: m_cyc_i sampled high at edge n in IDLE -> grant_o and s_cyc_o high from cycle n+1; response paths zero-latency.
- Back-to-back: release always costs exactly one IDLE cycle with s_cyc_o=0 before any new grant.
- Termination in the same cycle the counter reaches limit: termination wins, no abort.
- Owner drops m_cyc_i in the limit cycle: no abort, go IDLE.
- Requests arriving during OWN wait; never preempt.
- NUM_MASTERS=1: always grants master 0; ARB_MODE irrelevant.
- rst_i asserted mid-transfer: immediate return to reset state, s_cyc_o low asynchronously, no ERR issued.

## Test plan
- Single master 0 read, slave acks on 3rd cycle: s_adr_o = m_adr_i[0], m_ack_o=2'b01 that cycle, m_dat_o = 0xDEADBEEF read value; grant drops one cycle after m_cyc_i falls.
- ARB_MODE=0, both masters request same edge, repeated 4 times: master 0 wins all 4; master 1 granted only when master 0 idle.
- ARB_MODE=1, both request continuously, 4 single transfers: grant order 0,1,0,1, each separated by one IDLE cycle.
- Master 1 4-beat incrementing burst (cti 3'b010..3'b111) while master 0 requests: burst completes unsplit, master 0 granted after.
- TIMEOUT_CYCLES=8, slave never acks: m_err_o[owner] and timeout_o pulse one cycle after counter reaches 8, s_cyc_o low that cycle; ack on that cycle instead -> no abort.
- rst_i pulsed mid-burst: all outputs 0 immediately; next request granted normally with rr pointer 0.
